video_dma_desc_queue: RTL and testbench
=======================================

Name: video_dma_desc_queue

Overview:
Descriptor queue that sits directly upstream of the video DMA controller.
- CPU side: a small register interface stages a descriptor (source, length, destination) and commits it into a FIFO.
- DMA side: the head descriptor is presented on valid/field outputs; the DMA pops it when it accepts the transfer.
- Commits are validated before queuing; failures set sticky error flags.

Parameters:
DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries)
VIDEOMEM_SIZE, 18, video memory address width; destination field width and range-check bound

Ports:
clk  in  1  bus clock
rst  in  1  asynchronous, active-low reset
reg_we  in  1  register write strobe
reg_re  in  1  register read strobe
reg_addr  in  2  0=SRC, 1=LEN, 2=DST, 3=CTRL/STATUS
reg_wdata  in  32  write data
reg_rdata  out  32  read data, registered
desc_valid  out  1  head entry valid (drives DMA descp_avail)
desc_read_from  out  16  head source address
desc_length  out  16  head length in beats
desc_write_to  out  VIDEOMEM_SIZE  head destination address
desc_pop  in  1  DMA accepted head entry this cycle
irq_err  out  1  OR of all sticky error flags

Behaviour:
- Reset (rst low, async): FIFO empty, pointers 0, staging regs 0, written-mask 0, all errors 0, reg_rdata 0, desc_valid 0, desc_* fields 0.
- Writes to addr 0/1/2 load staging SRC[15:0] / LEN[15:0] / DST[VIDEOMEM_SIZE-1:0] from reg_wdata and set the matching written-mask bit.
- Write to addr 3 decodes reg_wdata bits:
  - bit0 = commit
  - bit1 = flush
  - bit2 = clear all error flags
- Commit checks, in priority order; the first failure rejects the commit (nothing enqueued):
  - mask != 3'b111 -> err_incomplete
  - LEN == 0 -> err_len
  - zero-ext DST + zero-ext LEN, computed in VIDEOMEM_SIZE+1 bits, > 2^VIDEOMEM_SIZE -> err_range
  - FIFO full and no same-cycle pop -> err_ovf
- Successful commit: enqueue {SRC, LEN, DST} and clear the mask. Staging values are retained, so they can be re-written selectively.
- A rejected commit leaves the mask unchanged.
- Error clear (bit2) takes effect before new errors in the same write: an error raised by a commit in that same write remains set.
- Flush (bit1): pointers and count reset next cycle. Flush beats commit and pop in the same cycle; both are discarded with no error.
- Pop: on desc_pop with desc_valid, the read pointer advances. desc_pop while empty is ignored, with no error.
- Simultaneous pop and commit while full: push accepted, count unchanged.
- Simultaneous pop and commit while empty: commit enqueues, pop ignored.
- Output timing:
  - desc_* are the registered head entry; desc_valid = (count != 0).
  - A commit into an empty FIFO raises desc_valid on the cycle after the write (latency 1).
  - After a pop, the next entry appears on the following cycle.
  - Fields are stable while desc_valid is high and no pop occurs.
- Count width is DEPTH_LOG2+1. Pointers are DEPTH_LOG2 bits and wrap naturally modulo depth.
- Reads: reg_rdata updates the cycle after reg_re and holds otherwise.
  - Addr 0/1/2 return the zero-extended staging value.
  - Addr 3 returns STATUS: [0] empty, [1] full, [2] err_ovf, [3] err_len, [4] err_range, [5] err_incomplete, [15:8] count zero-extended, others 0.
- irq_err is registered and updates with the flags.
- Reset mid-operation: all state is lost immediately, and desc_valid drops asynchronously.

Test Plan:
- Reset then write SRC=0x1000, LEN=0x0040, DST=0x00200, CTRL=1 -> next cycle desc_valid=1, fields 0x1000/0x0040/0x00200; STATUS reads count=1, empty=0.
- Commit 8 valid descriptors, then a 9th -> full=1, err_ovf=1, irq_err=1, count=8. Pulse desc_pop with commit while full -> accepted, count stays 8, FIFO order preserved.
- LEN=0 commit -> err_len=1, nothing queued. DST=0x3FFC0, LEN=0x41 -> err_range=1. DST=0x3FFC0, LEN=0x40 (exact end) -> accepted.
- Commit after writing only SRC and LEN -> err_incomplete=1, count unchanged. Write DST, then commit -> accepted.
- Queue 3 entries, write CTRL=3 (flush+commit) with desc_pop=1 -> next cycle count=0, desc_valid=0, no error flags. CTRL=4 clears errors and irq_err.
- Queue 2 entries, drive rst low mid-cycle -> desc_valid=0 immediately; after release STATUS=empty, count 0, staging regs read 0.

Source files
------------

// File: rtl/video_dma_desc_queue.sv
// -----------------------------------------------------------------------------
// video_dma_desc_queue
//
// Descriptor queue sitting directly upstream of the video DMA controller.
// The CPU stages a descriptor (source, length, destination) through a small
// register interface and commits it into a FIFO. Each commit is validated
// before it is queued. The DMA sees the head entry on desc_valid/desc_* and
// pops it with desc_pop when it accepts the transfer.
//
// Ports:
//   clk             bus clock
//   rst             asynchronous, active-low reset
//   reg_we/reg_re   register write/read strobes
//   reg_addr        0=SRC, 1=LEN, 2=DST, 3=CTRL (write) / STATUS (read)
//   reg_wdata       write data
//   reg_rdata       registered read data, updated the cycle after reg_re
//   desc_valid      head entry valid (FIFO not empty)
//   desc_read_from  head source address
//   desc_length     head length in beats
//   desc_write_to   head destination address
//   desc_pop        DMA accepted the head entry this cycle
//   irq_err         registered OR of all sticky error flags
//
// CTRL write bits: [0] commit, [1] flush, [2] clear error flags.
// STATUS: [0] empty, [1] full, [2] err_ovf, [3] err_len, [4] err_range,
//         [5] err_incomplete, [15:8] count.
// -----------------------------------------------------------------------------
module video_dma_desc_queue #(
  parameter int DEPTH_LOG2    = 3,
  parameter int VIDEOMEM_SIZE = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_we,
  input  logic                     reg_re,
  input  logic [1:0]               reg_addr,
  input  logic [31:0]              reg_wdata,
  output logic [31:0]              reg_rdata,
  output logic                     desc_valid,
  output logic [15:0]              desc_read_from,
  output logic [15:0]              desc_length,
  output logic [VIDEOMEM_SIZE-1:0] desc_write_to,
  input  logic                     desc_pop,
  output logic                     irq_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [VIDEOMEM_SIZE:0] VMEM_END = {1'b1, {VIDEOMEM_SIZE{1'b0}}};

  // A transfer may end exactly at the top of video memory but not beyond it.
  function automatic logic exceeds_vmem(input logic [VIDEOMEM_SIZE-1:0] dst,
                                        input logic [15:0]              len);
    logic [VIDEOMEM_SIZE:0] end_addr;
    end_addr = {1'b0, dst} + (VIDEOMEM_SIZE+1)'(len);
    return end_addr > VMEM_END;
  endfunction

  // Staging registers and the written-mask ({DST, LEN, SRC})
  logic [15:0]              stg_src;
  logic [15:0]              stg_len;
  logic [VIDEOMEM_SIZE-1:0] stg_dst;
  logic [2:0]               stg_mask;

  // FIFO storage and control
  logic [15:0]              src_mem [DEPTH];
  logic [15:0]              len_mem [DEPTH];
  logic [VIDEOMEM_SIZE-1:0] dst_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]    wr_ptr;
  logic [DEPTH_LOG2-1:0]    rd_ptr;
  logic [CW-1:0]            count;

  logic err_ovf;
  logic err_len;
  logic err_range;
  logic err_incomplete;

  // Combinational decode / next-state
  logic                     ctrl_wr;
  logic                     do_commit;
  logic                     do_flush;
  logic                     do_clear;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     pop_acc;
  logic                     push;
  logic                     set_ovf;
  logic                     set_len;
  logic                     set_range;
  logic                     set_incomplete;
  logic                     err_ovf_nxt;
  logic                     err_len_nxt;
  logic                     err_range_nxt;
  logic                     err_incomplete_nxt;
  logic [CW-1:0]            count_after_pop;
  logic [CW-1:0]            count_nxt;
  logic [DEPTH_LOG2-1:0]    wr_ptr_nxt;
  logic [DEPTH_LOG2-1:0]    rd_ptr_nxt;
  logic [15:0]              head_src_nxt;
  logic [15:0]              head_len_nxt;
  logic [VIDEOMEM_SIZE-1:0] head_dst_nxt;
  logic [31:0]              status;
  logic                     unused_wdata;

  // Upper write-data bits are don't-care for the narrower registers.
  assign unused_wdata = ^reg_wdata;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign desc_valid = !fifo_empty;

  // ---- decode and commit validation ----
  always_comb begin
    ctrl_wr   = reg_we && (reg_addr == 2'd3);
    do_commit = ctrl_wr && reg_wdata[0];
    do_flush  = ctrl_wr && reg_wdata[1];
    do_clear  = ctrl_wr && reg_wdata[2];
    // A flush discards any same-cycle pop or commit.
    pop_acc   = desc_pop && !fifo_empty && !do_flush;

    push           = 1'b0;
    set_ovf        = 1'b0;
    set_len        = 1'b0;
    set_range      = 1'b0;
    set_incomplete = 1'b0;
    if (do_commit && !do_flush) begin
      if (stg_mask != 3'b111)                  set_incomplete = 1'b1;
      else if (stg_len == 16'd0)               set_len        = 1'b1;
      else if (exceeds_vmem(stg_dst, stg_len)) set_range      = 1'b1;
      else if (fifo_full && !pop_acc)          set_ovf        = 1'b1;
      else                                     push           = 1'b1;
    end

    // Clear acts first so a same-write failure stays visible.
    err_ovf_nxt        = (err_ovf        && !do_clear) || set_ovf;
    err_len_nxt        = (err_len        && !do_clear) || set_len;
    err_range_nxt      = (err_range      && !do_clear) || set_range;
    err_incomplete_nxt = (err_incomplete && !do_clear) || set_incomplete;
  end

  // ---- pointer/count next-state and head look-ahead ----
  always_comb begin
    count_after_pop = count - CW'(pop_acc);
    if (do_flush) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      count_nxt  = count_after_pop + CW'(push);
      wr_ptr_nxt = wr_ptr + DEPTH_LOG2'(push);
      rd_ptr_nxt = rd_ptr + DEPTH_LOG2'(pop_acc);
    end

    // When the entry being pushed becomes the head, it is not in memory yet,
    // so take it straight from the staging registers.
    if (push && (count_after_pop == '0)) begin
      head_src_nxt = stg_src;
      head_len_nxt = stg_len;
      head_dst_nxt = stg_dst;
    end else begin
      head_src_nxt = src_mem[rd_ptr_nxt];
      head_len_nxt = len_mem[rd_ptr_nxt];
      head_dst_nxt = dst_mem[rd_ptr_nxt];
    end

    status = {16'd0, 8'(count), 2'b00, err_incomplete, err_range, err_len,
              err_ovf, fifo_full, fifo_empty};
  end

  // ---- FIFO storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr] <= stg_src;
      len_mem[wr_ptr] <= stg_len;
      dst_mem[wr_ptr] <= stg_dst;
    end
  end

  // ---- control state, staging, head and read-data registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_src        <= '0;
      stg_len        <= '0;
      stg_dst        <= '0;
      stg_mask       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_ovf        <= 1'b0;
      err_len        <= 1'b0;
      err_range      <= 1'b0;
      err_incomplete <= 1'b0;
      irq_err        <= 1'b0;
      reg_rdata      <= '0;
      desc_read_from <= '0;
      desc_length    <= '0;
      desc_write_to  <= '0;
    end else begin
      if (reg_we) begin
        case (reg_addr)
          2'd0: begin
            stg_src     <= reg_wdata[15:0];
            stg_mask[0] <= 1'b1;
          end
          2'd1: begin
            stg_len     <= reg_wdata[15:0];
            stg_mask[1] <= 1'b1;
          end
          2'd2: begin
            stg_dst     <= reg_wdata[VIDEOMEM_SIZE-1:0];
            stg_mask[2] <= 1'b1;
          end
          default: begin
            if (push) stg_mask <= 3'b000;
          end
        endcase
      end

      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;

      err_ovf        <= err_ovf_nxt;
      err_len        <= err_len_nxt;
      err_range      <= err_range_nxt;
      err_incomplete <= err_incomplete_nxt;
      irq_err        <= err_ovf_nxt || err_len_nxt || err_range_nxt || err_incomplete_nxt;

      // Fields hold while the queue is empty; only a live head is loaded.
      if (count_nxt != '0) begin
        desc_read_from <= head_src_nxt;
        desc_length    <= head_len_nxt;
        desc_write_to  <= head_dst_nxt;
      end

      if (reg_re) begin
        case (reg_addr)
          2'd0:    reg_rdata <= 32'(stg_src);
          2'd1:    reg_rdata <= 32'(stg_len);
          2'd2:    reg_rdata <= 32'(stg_dst);
          default: reg_rdata <= status;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_dma_desc_queue.sv
module tb_video_dma_desc_queue;

  localparam int DL    = 3;
  localparam int VS    = 18;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_we;
  logic          reg_re;
  logic [1:0]    reg_addr;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata;
  logic          desc_valid;
  logic [15:0]   desc_read_from;
  logic [15:0]   desc_length;
  logic [VS-1:0] desc_write_to;
  logic          desc_pop;
  logic          irq_err;

  video_dma_desc_queue #(.DEPTH_LOG2(DL), .VIDEOMEM_SIZE(VS)) dut (
    .clk(clk), .rst(rst), .reg_we(reg_we), .reg_re(reg_re),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .desc_valid(desc_valid), .desc_read_from(desc_read_from),
    .desc_length(desc_length), .desc_write_to(desc_write_to),
    .desc_pop(desc_pop), .irq_err(irq_err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of descriptors plus staging and sticky flags.
  typedef struct packed {
    logic [15:0]   src;
    logic [15:0]   len;
    logic [VS-1:0] dst;
  } desc_t;

  desc_t         mq[$];
  logic [15:0]   m_src, m_len;
  logic [VS-1:0] m_dst;
  logic [2:0]    m_mask;
  logic          m_ovf, m_lenerr, m_range, m_inc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_src = '0; m_len = '0; m_dst = '0; m_mask = '0;
    m_ovf = 0; m_lenerr = 0; m_range = 0; m_inc = 0;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0]    = (mq.size() == 0);
    s[1]    = (mq.size() == DEPTH);
    s[2]    = m_ovf;
    s[3]    = m_lenerr;
    s[4]    = m_range;
    s[5]    = m_inc;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_src);
      2'd1:    return 32'(m_len);
      2'd2:    return 32'(m_dst);
      default: return model_status();
    endcase
  endfunction

  task automatic model_step(input logic we, input logic [1:0] a,
                            input logic [31:0] wd, input logic pop);
    bit ctrl, popped, ok;
    ctrl = we && (a == 2'd3);
    if (ctrl && wd[2]) begin
      m_ovf = 0; m_lenerr = 0; m_range = 0; m_inc = 0;
    end
    if (ctrl && wd[1]) begin
      mq.delete();
    end else begin
      popped = pop && (mq.size() != 0);
      ok = 0;
      if (ctrl && wd[0]) begin
        if (m_mask != 3'b111)                       m_inc = 1;
        else if (m_len == 0)                        m_lenerr = 1;
        else if (int'(m_dst) + int'(m_len) > (1 << VS)) m_range = 1;
        else if (mq.size() == DEPTH && !popped)     m_ovf = 1;
        else                                        ok = 1;
      end
      if (popped) void'(mq.pop_front());
      if (ok) begin
        mq.push_back({m_src, m_len, m_dst});
        m_mask = 3'b000;
      end
    end
    if (we) begin
      case (a)
        2'd0: begin m_src = wd[15:0];   m_mask[0] = 1'b1; end
        2'd1: begin m_len = wd[15:0];   m_mask[1] = 1'b1; end
        2'd2: begin m_dst = wd[VS-1:0]; m_mask[2] = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    check("desc_valid", desc_valid, (mq.size() != 0));
    check("irq_err", irq_err, m_ovf | m_lenerr | m_range | m_inc);
    if (mq.size() != 0) begin
      check("desc_read_from", desc_read_from, mq[0].src);
      check("desc_length", desc_length, mq[0].len);
      check("desc_write_to", desc_write_to, mq[0].dst);
    end
  endtask

  // One bus cycle: drive at negedge, update model at posedge, check at next negedge.
  task automatic cycle(input logic we, input logic re, input logic [1:0] a,
                       input logic [31:0] wd, input logic pop);
    logic [31:0] exp_rd;
    reg_we = we; reg_re = re; reg_addr = a; reg_wdata = wd; desc_pop = pop;
    exp_rd = model_read(a);
    @(posedge clk);
    model_step(we, a, wd, pop);
    @(negedge clk);
    reg_we = 0; reg_re = 0; reg_addr = 0; reg_wdata = 0; desc_pop = 0;
    if (re) check("reg_rdata", reg_rdata, exp_rd);
    check_outputs();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    cycle(1'b1, 1'b0, a, wd, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(1'b0, 1'b1, a, 32'd0, 1'b0);
  endtask

  task automatic write_desc(input logic [15:0] s, input logic [15:0] l, input logic [VS-1:0] d);
    wr(2'd0, 32'(s));
    wr(2'd1, 32'(l));
    wr(2'd2, 32'(d));
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && mq.size() != 0; k++)
      cycle(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; reg_we = 0; reg_re = 0; reg_addr = 0; reg_wdata = 0; desc_pop = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_valid", desc_valid, 0);
    check("reset_irq", irq_err, 0);
    check("reset_rdata", reg_rdata, 0);
    check("reset_src", desc_read_from, 0);
    check("reset_len", desc_length, 0);
    check("reset_dst", desc_write_to, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single descriptor, latency 1
    write_desc(16'h1000, 16'h0040, 18'h00200);
    wr(2'd3, 32'h1);
    check("tp1_valid", desc_valid, 1);
    check("tp1_src", desc_read_from, 16'h1000);
    check("tp1_len", desc_length, 16'h0040);
    check("tp1_dst", desc_write_to, 18'h00200);
    rd(2'd3);
    check("tp1_status", reg_rdata, 32'h0000_0100);

    // Fill to full, then overflow
    for (int i = 1; i < DEPTH; i++) begin
      write_desc(16'(16'h2000 + i), 16'(i * 4), 18'(i * 16'h100));
      wr(2'd3, 32'h1);
    end
    write_desc(16'h3333, 16'h0010, 18'h01000);
    wr(2'd3, 32'h1);
    check("ovf_irq", irq_err, 1);
    rd(2'd3);
    check("ovf_status", reg_rdata, 32'h0000_0806);
    // Commit with a same-cycle pop while full is accepted
    cycle(1'b1, 1'b0, 2'd3, 32'h1, 1'b1);
    rd(2'd3);
    check("full_pop_commit_status", reg_rdata, 32'h0000_0806);
    drain();
    wr(2'd3, 32'h4);
    check("clear_irq", irq_err, 0);

    // Length and range checks
    write_desc(16'h0001, 16'h0000, 18'h00000);
    wr(2'd3, 32'h1);
    rd(2'd3);
    check("len0_status", reg_rdata, 32'h0000_0009);
    wr(2'd1, 32'h41);
    wr(2'd2, 32'h3FFC0);
    wr(2'd3, 32'h1);
    rd(2'd3);
    check("range_status", reg_rdata, 32'h0000_0019);
    wr(2'd1, 32'h40);
    wr(2'd3, 32'h5);
    rd(2'd3);
    check("exact_end_status", reg_rdata, 32'h0000_0100);
    check("exact_end_dst", desc_write_to, 18'h3FFC0);

    // Incomplete staging
    wr(2'd0, 32'h0AAA);
    wr(2'd1, 32'h0008);
    wr(2'd3, 32'h1);
    rd(2'd3);
    check("incomplete_status", reg_rdata, 32'h0000_0120);
    wr(2'd2, 32'h00400);
    wr(2'd3, 32'h1);
    rd(2'd3);
    check("incomplete_fixed_status", reg_rdata, 32'h0000_0220);
    wr(2'd3, 32'h4);
    drain();

    // Flush beats commit and pop
    for (int i = 0; i < 3; i++) begin
      write_desc(16'(16'h4000 + i), 16'h0020, 18'(16'h800 * i));
      wr(2'd3, 32'h1);
    end
    cycle(1'b1, 1'b0, 2'd3, 32'h3, 1'b1);
    check("flush_valid", desc_valid, 0);
    check("flush_irq", irq_err, 0);
    rd(2'd3);
    check("flush_status", reg_rdata, 32'h0000_0001);
    wr(2'd3, 32'h1); // mask is clear -> incomplete error
    check("pre_clear_irq", irq_err, 1);
    wr(2'd3, 32'h4);
    check("ctrl4_irq", irq_err, 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 2; i++) begin
      write_desc(16'(16'h5000 + i), 16'h0010, 18'h00100);
      wr(2'd3, 32'h1);
    end
    check("pre_reset_valid", desc_valid, 1);
    #2 rst = 1'b0;
    #1 check("async_reset_valid", desc_valid, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    rd(2'd3);
    check("post_reset_status", reg_rdata, 32'h0000_0001);
    rd(2'd0);
    check("post_reset_src", reg_rdata, 0);
    rd(2'd1);
    rd(2'd2);
    check("post_reset_dst", reg_rdata, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        we, re, pop;
      logic [1:0]  a;
      logic [31:0] wd;
      int          r;
      r   = $urandom_range(0, 9);
      we  = (r < 8);
      re  = ($urandom_range(0, 9) < 3);
      pop = ($urandom_range(0, 99) < 35);
      wd  = $urandom;
      a   = 2'($urandom_range(0, 3));
      if (r < 2) begin
        a = 2'd0;
      end else if (r < 3) begin
        a  = 2'd1;
        wd = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(1, 16'h800));
      end else if (r < 4) begin
        a  = 2'd2;
        wd = ($urandom_range(0, 7) == 0) ? 32'((1 << VS) - $urandom_range(1, 16'h900))
                                          : 32'($urandom_range(0, 16'hFFFF));
      end else if (r < 8) begin
        a  = 2'd3;
        wd = 32'h1;
        if ($urandom_range(0, 31) == 0) wd[1] = 1'b1;
        if ($urandom_range(0, 15) == 0) wd[2] = 1'b1;
      end
      if (!we && !re) a = 2'd0;
      cycle(we, re, a, wd, pop);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
